// File: rtl/flash_rom_loader.sv
// Boot loader: copies a ROM image from SPI flash into SRAM,
// then releases the Z80 from reset and hands the SPI pins back.
module flash_rom_loader #(
  parameter logic [23:0] FLASH_BASE = 24'h100000,
  parameter logic [15:0] RAM_BASE   = 16'h4000,
  parameter int          LOAD_BYTES = 2048,
  parameter int          CLK_DIV    = 2,
  parameter int          PWR_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reload,
  input  logic        spi_miso,
  output logic        spi_clk,
  output logic        spi_out,
  output logic        spi_cs,
  output logic        spi_oe,
  output logic [15:0] ram_address,
  output logic [7:0]  ram_datain,
  output logic        ram_cs,
  output logic        ram_we,
  output logic        cpu_rst_n,
  output logic        done
);

  localparam int WW = $clog2(PWR_CYCLES + CLK_DIV + 2);
  localparam int DW = $clog2(CLK_DIV + 1);

  localparam logic [WW-1:0] PWR_LAST  = WW'(PWR_CYCLES - 1);
  localparam logic [WW-1:0] HALF_LAST = WW'(CLK_DIV - 1);
  localparam logic [WW-1:0] HALF      = WW'(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [15:0]   LAST_IDX  = 16'(LOAD_BYTES - 1);
  localparam logic [31:0]   CMD       = {8'h03, FLASH_BASE};

  typedef enum logic [2:0] {
    PWR_WAIT,
    CS_SETUP,
    SEND,
    RECV,
    FINISH,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WW-1:0] wait_q, wait_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    bit_q, bit_d;
  logic [2:0]    rx_q, rx_d;
  logic [7:0]    sh_q, sh_d;
  logic [31:0]   cmd_q, cmd_d;
  logic [15:0]   idx_q, idx_d;

  logic          spi_clk_q, spi_clk_d;
  logic          spi_out_q, spi_out_d;
  logic          spi_cs_q, spi_cs_d;
  logic          spi_oe_q, spi_oe_d;
  logic [15:0]   ram_address_q, ram_address_d;
  logic [7:0]    ram_datain_q, ram_datain_d;
  logic          ram_cs_q, ram_cs_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;
  logic          done_q, done_d;

  logic          tick;
  logic          rise;
  logic          start;
  logic [7:0]    rx_byte;

  assign tick = (div_q == DIV_LAST);
  assign rise = tick && !spi_clk_q;

  // Next-state, SCK generation, shifting and SRAM write pulses
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    div_d         = div_q;
    bit_d         = bit_q;
    rx_d          = rx_q;
    sh_d          = sh_q;
    cmd_d         = cmd_q;
    idx_d         = idx_q;
    spi_clk_d     = spi_clk_q;
    spi_out_d     = spi_out_q;
    spi_cs_d      = spi_cs_q;
    ram_address_d = ram_address_q;
    ram_datain_d  = ram_datain_q;
    ram_cs_d      = 1'b0;
    start         = 1'b0;
    rx_byte       = {sh_q[6:0], spi_miso};

    unique case (state_q)
      PWR_WAIT: begin
        if (wait_q == PWR_LAST) begin
          start = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      CS_SETUP: begin
        if (wait_q == HALF_LAST) begin
          state_d = SEND;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      SEND: begin
        if (tick) begin
          div_d     = '0;
          spi_clk_d = !spi_clk_q;
          if (rise) begin
            bit_d = bit_q + 1'b1;
            if (bit_q == 5'd31) begin
              state_d   = RECV;
              spi_out_d = 1'b0;
              rx_d      = '0;
            end
          end else begin
            cmd_d     = {cmd_q[30:0], 1'b0};
            spi_out_d = cmd_q[30];
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      RECV: begin
        if (tick) begin
          div_d     = '0;
          spi_clk_d = !spi_clk_q;
          if (rise) begin
            sh_d = rx_byte;
            rx_d = rx_q + 1'b1;
            if (rx_q == 3'd7) begin
              ram_datain_d  = rx_byte;
              ram_address_d = RAM_BASE + idx_q;
              ram_cs_d      = 1'b1;
              idx_d         = idx_q + 1'b1;
              if (idx_q == LAST_IDX) begin
                state_d = FINISH;
                wait_d  = '0;
              end
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      FINISH: begin
        if (wait_q == HALF) begin
          state_d = DONE;
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_q == HALF_LAST) begin
            spi_clk_d = 1'b0;
            spi_cs_d  = 1'b1;
          end
        end
      end

      DONE: begin
        spi_cs_d  = 1'b1;
        spi_clk_d = 1'b0;
        if (reload) begin
          start = 1'b1;
        end
      end

      default: begin
        state_d = PWR_WAIT;
      end
    endcase

    if (start) begin
      state_d   = CS_SETUP;
      wait_d    = '0;
      idx_d     = '0;
      cmd_d     = CMD;
      spi_cs_d  = 1'b0;
      spi_clk_d = 1'b0;
      spi_out_d = CMD[31];
    end

    done_d      = (state_d == DONE);
    cpu_rst_n_d = (state_d == DONE);
    spi_oe_d    = (state_d != DONE);
  end

  // State and output registers, async active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= PWR_WAIT;
      wait_q        <= '0;
      div_q         <= '0;
      bit_q         <= '0;
      rx_q          <= '0;
      sh_q          <= '0;
      cmd_q         <= '0;
      idx_q         <= '0;
      spi_clk_q     <= 1'b0;
      spi_out_q     <= 1'b0;
      spi_cs_q      <= 1'b1;
      spi_oe_q      <= 1'b1;
      ram_address_q <= RAM_BASE;
      ram_datain_q  <= '0;
      ram_cs_q      <= 1'b0;
      cpu_rst_n_q   <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      div_q         <= div_d;
      bit_q         <= bit_d;
      rx_q          <= rx_d;
      sh_q          <= sh_d;
      cmd_q         <= cmd_d;
      idx_q         <= idx_d;
      spi_clk_q     <= spi_clk_d;
      spi_out_q     <= spi_out_d;
      spi_cs_q      <= spi_cs_d;
      spi_oe_q      <= spi_oe_d;
      ram_address_q <= ram_address_d;
      ram_datain_q  <= ram_datain_d;
      ram_cs_q      <= ram_cs_d;
      cpu_rst_n_q   <= cpu_rst_n_d;
      done_q        <= done_d;
    end
  end

  assign spi_clk     = spi_clk_q;
  assign spi_out     = spi_out_q;
  assign spi_cs      = spi_cs_q;
  assign spi_oe      = spi_oe_q;
  assign ram_address = ram_address_q;
  assign ram_datain  = ram_datain_q;
  assign ram_cs      = ram_cs_q;
  assign ram_we      = ram_cs_q;
  assign cpu_rst_n   = cpu_rst_n_q;
  assign done        = done_q;

endmodule

// File: tb/tb_flash_rom_loader.sv
// Bench for flash_rom_loader: flash models, SRAM write
// capture and directed load / reload / reset sequences.
module tb_flash_rom_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic reload = 1'b0;
  logic reload1 = 1'b0;
  logic miso0, miso1;

  logic sck0, mosi0, cs0, oe0, rcs0, rwe0, crn0, done0;
  logic sck1, mosi1, cs1, oe1, rcs1, rwe1, crn1, done1;
  logic [15:0] ra0, ra1;
  logic [7:0]  rd0, rd1;

  always #5 clk = ~clk;

  flash_rom_loader #(
    .FLASH_BASE(24'h100000), .RAM_BASE(16'h4000),
    .LOAD_BYTES(4), .CLK_DIV(2), .PWR_CYCLES(16)
  ) u0 (
    .clk(clk), .rst(rst), .reload(reload),
    .spi_miso(miso0), .spi_clk(sck0), .spi_out(mosi0),
    .spi_cs(cs0), .spi_oe(oe0), .ram_address(ra0),
    .ram_datain(rd0), .ram_cs(rcs0), .ram_we(rwe0),
    .cpu_rst_n(crn0), .done(done0)
  );

  flash_rom_loader #(
    .FLASH_BASE(24'h100000), .RAM_BASE(16'h4000),
    .LOAD_BYTES(1), .CLK_DIV(1), .PWR_CYCLES(16)
  ) u1 (
    .clk(clk), .rst(rst), .reload(reload1),
    .spi_miso(miso1), .spi_clk(sck1), .spi_out(mosi1),
    .spi_cs(cs1), .spi_oe(oe1), .ram_address(ra1),
    .ram_datain(rd1), .ram_cs(rcs1), .ram_we(rwe1),
    .cpu_rst_n(crn1), .done(done1)
  );

  typedef struct {
    logic [7:0]  fbyte;
    logic [15:0] addr;
    logic [7:0]  data;
  } vec_t;

  vec_t tbl [4];
  logic [7:0] img0 [4];
  logic [7:0] img1;

  int checks = 0;
  int errors = 0;

  int r0 = 0, r1 = 0;
  logic [31:0] cmd0 = '0, cmd1 = '0;

  // Flash models: capture MOSI on SCK rise, drive data on SCK fall
  always @(negedge cs0 or posedge sck0) begin
    if (sck0 && !cs0) begin
      if (r0 < 32) cmd0 = {cmd0[30:0], mosi0};
      r0++;
    end else if (!cs0) begin
      r0 = 0;
      cmd0 = '0;
    end
  end

  always @(negedge sck0) begin
    if (!cs0 && r0 >= 32 && r0 < 64)
      miso0 = img0[(r0-32)/8][7-((r0-32)%8)];
  end

  always @(negedge cs1 or posedge sck1) begin
    if (sck1 && !cs1) begin
      if (r1 < 32) cmd1 = {cmd1[30:0], mosi1};
      r1++;
    end else if (!cs1) begin
      r1 = 0;
      cmd1 = '0;
    end
  end

  always @(negedge sck1) begin
    if (!cs1 && r1 >= 32 && r1 < 40)
      miso1 = img1[7-(r1-32)];
  end

  logic [15:0] wa0 [$];
  logic [7:0]  wd0 [$];
  logic [15:0] wa1 [$];
  logic [7:0]  wd1 [$];
  int wemis;
  int cyc = 0;
  int pmin0, pmax0, last0, pmin1, pmax1, last1;
  logic psck0 = 1'b0, psck1 = 1'b0;

  // Write capture and SCK period measurement, sampled on negedge
  always @(negedge clk) begin
    cyc++;
    if (rcs0 || rwe0) begin
      wa0.push_back(ra0);
      wd0.push_back(rd0);
      if (rcs0 !== rwe0) wemis++;
    end
    if (rcs1 || rwe1) begin
      wa1.push_back(ra1);
      wd1.push_back(rd1);
      if (rcs1 !== rwe1) wemis++;
    end
    if (sck0 && !psck0) begin
      if (last0 >= 0) begin
        if (cyc - last0 < pmin0) pmin0 = cyc - last0;
        if (cyc - last0 > pmax0) pmax0 = cyc - last0;
      end
      last0 = cyc;
    end
    if (sck1 && !psck1) begin
      if (last1 >= 0) begin
        if (cyc - last1 < pmin1) pmin1 = cyc - last1;
        if (cyc - last1 > pmax1) pmax1 = cyc - last1;
      end
      last1 = cyc;
    end
    psck0 = sck0;
    psck1 = sck1;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic clear();
    #1;
    wa0.delete(); wd0.delete();
    wa1.delete(); wd1.delete();
    wemis = 0;
    pmin0 = 1000; pmax0 = 0; last0 = -1;
    pmin1 = 1000; pmax1 = 0; last1 = -1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_cs"}, 32'(cs0), 32'd1);
    chk({nm, "_sck"}, 32'(sck0), 32'd0);
    chk({nm, "_mosi"}, 32'(mosi0), 32'd0);
    chk({nm, "_oe"}, 32'(oe0), 32'd1);
    chk({nm, "_ramcs"}, 32'(rcs0), 32'd0);
    chk({nm, "_ramwe"}, 32'(rwe0), 32'd0);
    chk({nm, "_addr"}, 32'(ra0), 32'h4000);
    chk({nm, "_data"}, 32'(rd0), 32'd0);
    chk({nm, "_cpurst"}, 32'(crn0), 32'd0);
    chk({nm, "_done"}, 32'(done0), 32'd0);
  endtask

  task automatic pwr_wait(input string nm);
    int n;
    int bad;
    n = 0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (crn0 || sck0) bad++;
      if (!cs0) break;
    end
    chk({nm, "_len"}, 32'(n), 32'd16);
    chk({nm, "_quiet"}, 32'(bad), 32'd0);
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done0) break;
    end
    chk({nm, "_done_seen"}, 32'(done0), 32'd1);
  endtask

  task automatic wait_writes(input string nm, input int n);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (wa0.size() >= n) break;
    end
    chk({nm, "_writes_seen"}, 32'(wa0.size() >= n), 32'd1);
  endtask

  task automatic check_load(input string nm);
    chk({nm, "_rises"}, 32'(r0), 32'd64);
    chk({nm, "_cmd"}, cmd0, 32'h03100000);
    chk({nm, "_nwr"}, 32'(wa0.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wa0.size()) begin
        chk($sformatf("%s_addr%0d", nm, i),
            32'(wa0[i]), 32'(tbl[i].addr));
        chk($sformatf("%s_data%0d", nm, i),
            32'(wd0[i]), 32'(tbl[i].data));
      end
    end
    chk({nm, "_we_eq_cs"}, 32'(wemis), 32'd0);
    chk({nm, "_pmin"}, 32'(pmin0), 32'd4);
    chk({nm, "_pmax"}, 32'(pmax0), 32'd4);
    chk({nm, "_cs_hi"}, 32'(cs0), 32'd1);
    chk({nm, "_sck_lo"}, 32'(sck0), 32'd0);
    chk({nm, "_cpurst"}, 32'(crn0), 32'd1);
    chk({nm, "_oe"}, 32'(oe0), 32'd0);
  endtask

  initial begin
    tbl[0] = '{8'hA5, 16'h4000, 8'hA5};
    tbl[1] = '{8'h5A, 16'h4001, 8'h5A};
    tbl[2] = '{8'h00, 16'h4002, 8'h00};
    tbl[3] = '{8'hFF, 16'h4003, 8'hFF};
    for (int i = 0; i < 4; i++) img0[i] = tbl[i].fbyte;
    img1 = 8'h3C;
    clear();

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("por");

    @(negedge clk);
    rst = 1'b1;
    pwr_wait("pwr0");
    wait_done("load0");
    check_load("load0");

    chk("u1_done", 32'(done1), 32'd1);
    chk("u1_rises", 32'(r1), 32'd40);
    chk("u1_cmd", cmd1, 32'h03100000);
    chk("u1_nwr", 32'(wa1.size()), 32'd1);
    if (wa1.size() > 0) begin
      chk("u1_addr", 32'(wa1[0]), 32'h4000);
      chk("u1_data", 32'(wd1[0]), 32'h3C);
    end
    chk("u1_pmin", 32'(pmin1), 32'd2);
    chk("u1_pmax", 32'(pmax1), 32'd2);
    chk("u1_cpurst", 32'(crn1), 32'd1);

    @(negedge clk);
    clear();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("rl_done", 32'(done0), 32'd0);
    chk("rl_cpurst", 32'(crn0), 32'd0);
    chk("rl_cs", 32'(cs0), 32'd0);
    chk("rl_oe", 32'(oe0), 32'd1);

    wait_writes("rl_recv", 1);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("rl_recv_busy", 32'(done0), 32'd0);
    wait_done("reload");
    check_load("reload");

    @(negedge clk);
    clear();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    wait_writes("mid", 2);
    #2 rst = 1'b0;
    #1 chk_reset("midrst");
    repeat (2) @(negedge clk);
    clear();
    rst = 1'b1;
    pwr_wait("pwr1");
    wait_done("rerun");
    check_load("rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
